// File: rtl/vgachargen_apb_writer_if.sv
// APB completer bundle for the VGA character-generator memory writer.
// Signal names match the APB-side port names of the writer.
interface vgachargen_apb_writer_if;
  logic [15:0] paddr_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;

  modport master (
    output paddr_i, psel_i, penable_i,
    output pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  paddr_i, psel_i, penable_i,
    input  pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/vgachargen_apb_writer.sv
// APB completer driving port A of the ch_map, col_map and ch_t_rw BRAMs.
// Glyph writes are 32-bit byte-strobed read-modify-writes of a 128-bit row.
module vgachargen_apb_writer #(
  parameter int unsigned CH_MAP_ADDR_WIDTH  = 12,
  parameter int unsigned CH_MAP_DEPTH       = 2400,
  parameter int unsigned CH_MAP_DATA_WIDTH  = 8,
  parameter int unsigned COL_MAP_ADDR_WIDTH = 12,
  parameter int unsigned COL_MAP_DATA_WIDTH = 8,
  parameter int unsigned CH_T_ADDR_WIDTH    = 7,
  parameter int unsigned CH_T_DATA_WIDTH    = 128
) (
  input  logic clk_i,
  input  logic arstn_i,
  vgachargen_apb_writer_if.slave apb,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
  output logic                          ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_o,
  output logic                          col_map_wen_o,
  input  logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);

  typedef enum logic [1:0] {
    IDLE, ACC1, ACC2
  } state_e;

  typedef enum logic [1:0] {
    RG_CH, RG_COL, RG_GLY, RG_ERR
  } region_e;

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  region_e     dec_rg;
  logic        write_q, write_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;

  logic [11:0] idx;
  logic        in_range;
  logic        setup;
  logic        acc1, acc2;
  logic        is_map;
  logic        done1;
  logic [1:0]  slice;
  logic [31:0] old_slice, new_slice, rd_mux;
  logic [CH_T_DATA_WIDTH-1:0] merged;
  logic        unused_paddr;

  assign unused_paddr = ^apb.paddr_i[1:0];

  assign idx      = apb.paddr_i[13:2];
  assign in_range = 32'(idx) < CH_MAP_DEPTH;
  assign setup    = apb.psel_i & ~apb.penable_i;

  always_comb begin
    dec_rg = RG_ERR;
    unique case (1'b1)
      apb.paddr_i[15:14] == 2'b00:
        dec_rg = in_range ? RG_CH : RG_ERR;
      apb.paddr_i[15:14] == 2'b01:
        dec_rg = in_range ? RG_COL : RG_ERR;
      apb.paddr_i[15:11] == 5'b10000:
        dec_rg = RG_GLY;
      default: dec_rg = RG_ERR;
    endcase
  end

  assign is_map = (region_q == RG_CH) | (region_q == RG_COL);
  assign done1  = (region_q == RG_ERR) | (is_map & write_q);

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          region_d = dec_rg;
          write_d  = apb.pwrite_i;
          addr_d   = idx;
          wdata_d  = apb.pwdata_i;
          strb_d   = apb.pstrb_i;
          state_d  = ACC1;
        end
      end
      ACC1: begin
        if (!apb.psel_i || done1) state_d = IDLE;
        else                      state_d = ACC2;
      end
      ACC2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      region_q <= RG_ERR;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
    end
  end

  // Access-phase outputs vanish as soon as the master drops psel.
  assign acc1  = (state_q == ACC1) & apb.psel_i;
  assign acc2  = (state_q == ACC2) & apb.psel_i;
  assign slice = addr_q[1:0];

  always_comb begin
    old_slice = ch_t_rw_data_i[{slice, 5'b0} +: 32];
    new_slice = old_slice;
    for (int b = 0; b < 4; b++) begin
      if (strb_q[b]) new_slice[8*b +: 8] = wdata_q[8*b +: 8];
    end
    merged = ch_t_rw_data_i;
    merged[{slice, 5'b0} +: 32] = new_slice;
  end

  always_comb begin
    rd_mux = '0;
    unique case (region_q)
      RG_CH:   rd_mux = 32'(ch_map_data_i);
      RG_COL:  rd_mux = 32'(col_map_data_i);
      RG_GLY:  rd_mux = old_slice;
      default: rd_mux = '0;
    endcase
  end

  assign apb.pready_o  = (acc1 & done1) | acc2;
  assign apb.pslverr_o = acc1 & (region_q == RG_ERR);
  assign apb.prdata_o  = (acc2 & ~write_q) ? rd_mux : '0;

  assign ch_map_addr_o  = addr_q[CH_MAP_ADDR_WIDTH-1:0];
  assign ch_map_data_o  = wdata_q[CH_MAP_DATA_WIDTH-1:0];
  assign ch_map_wen_o   = acc1 & (region_q == RG_CH) & write_q & strb_q[0];

  assign col_map_addr_o = addr_q[COL_MAP_ADDR_WIDTH-1:0];
  assign col_map_data_o = wdata_q[COL_MAP_DATA_WIDTH-1:0];
  assign col_map_wen_o  = acc1 & (region_q == RG_COL) & write_q & strb_q[0];

  assign ch_t_rw_addr_o = addr_q[CH_T_ADDR_WIDTH+1:2];
  assign ch_t_rw_wen_o  = acc2 & (region_q == RG_GLY) & write_q;
  assign ch_t_rw_data_o = ch_t_rw_wen_o ? merged : '0;

endmodule

// File: tb/tb_vgachargen_apb_writer.sv
// Directed bench for vgachargen_apb_writer with behavioural port-A BRAMs.
// Vector table plus hand sequences for reset and psel abort.
module tb_vgachargen_apb_writer;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  vgachargen_apb_writer_if apb ();

  logic [11:0]  ch_map_addr, col_map_addr;
  logic [7:0]   ch_map_wd, col_map_wd, ch_map_rd, col_map_rd;
  logic         ch_map_wen, col_map_wen, ch_t_wen;
  logic [6:0]   ch_t_addr;
  logic [127:0] ch_t_wd, ch_t_rd;

  vgachargen_apb_writer dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .apb            (apb.slave),
    .ch_map_addr_o  (ch_map_addr),
    .ch_map_data_o  (ch_map_wd),
    .ch_map_wen_o   (ch_map_wen),
    .ch_map_data_i  (ch_map_rd),
    .col_map_addr_o (col_map_addr),
    .col_map_data_o (col_map_wd),
    .col_map_wen_o  (col_map_wen),
    .col_map_data_i (col_map_rd),
    .ch_t_rw_addr_o (ch_t_addr),
    .ch_t_rw_data_o (ch_t_wd),
    .ch_t_rw_wen_o  (ch_t_wen),
    .ch_t_rw_data_i (ch_t_rd)
  );

  logic [7:0]   chm  [4096];
  logic [7:0]   colm [4096];
  logic [127:0] glym [128];

  always @(posedge clk) begin
    if (ch_map_wen) chm[ch_map_addr] <= ch_map_wd;
    if (col_map_wen) colm[col_map_addr] <= col_map_wd;
    if (ch_t_wen) glym[ch_t_addr] <= ch_t_wd;
    ch_map_rd  <= chm[ch_map_addr];
    col_map_rd <= colm[col_map_addr];
    ch_t_rd    <= glym[ch_t_addr];
  end

  int n_chw = 0, n_colw = 0, n_gw = 0;
  logic [11:0]  last_cha = '0, last_cola = '0;
  logic [7:0]   last_chd = '0, last_cold = '0;
  logic [6:0]   last_ga = '0;
  logic [127:0] last_gd = '0;

  always @(negedge clk) begin
    if (ch_map_wen) begin
      n_chw++; last_cha = ch_map_addr; last_chd = ch_map_wd;
    end
    if (col_map_wen) begin
      n_colw++; last_cola = col_map_addr; last_cold = col_map_wd;
    end
    if (ch_t_wen) begin
      n_gw++; last_ga = ch_t_addr; last_gd = ch_t_wd;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    apb.psel_i = 1'b0;
    apb.penable_i = 1'b0;
    apb.pwrite_i = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er,
                      output int ws);
    logic done;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0;
    apb.paddr_i = a; apb.pwrite_i = w;
    apb.pwdata_i = d; apb.pstrb_i = s;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    ws = 0; rd = '0; er = 1'b0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (apb.pready_o) begin
        done = 1'b1; rd = apb.prdata_o; er = apb.pslverr_o;
      end else begin
        ws++;
      end
    end
    if (!done) chk("pready_timeout", 128'(done), 128'd1);
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_pready"}, 128'(apb.pready_o), 128'd0);
    chk({nm, "_pslverr"}, 128'(apb.pslverr_o), 128'd0);
    chk({nm, "_prdata"}, 128'(apb.prdata_o), 128'd0);
    chk({nm, "_wens"},
        128'({ch_map_wen, col_map_wen, ch_t_wen}), 128'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] rd;
    logic        er;
    int          ws;
    int          chw;
    int          colw;
    int          gw;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  logic [31:0] rd;
  logic        er;
  int          ws;
  int          c0, k0, g0;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      chm[i] = '0; colm[i] = '0;
    end
    for (int i = 0; i < 128; i++) glym[i] = '0;

    v[0]  = '{16'h0004, 1, 32'h0000_0085, 4'hF, 32'h0, 0, 0, 1, 0, 0};
    v[1]  = '{16'h0004, 0, 32'h0, 4'hF, 32'h85, 0, 1, 0, 0, 0};
    v[2]  = '{16'h657C, 1, 32'h0000_00A3, 4'hF, 32'h0, 0, 0, 0, 1, 0};
    v[3]  = '{16'h657C, 0, 32'h0, 4'hF, 32'hA3, 0, 1, 0, 0, 0};
    v[4]  = '{16'h6580, 1, 32'h0000_0055, 4'hF, 32'h0, 1, 0, 0, 0, 0};
    v[5]  = '{16'h9000, 0, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 0};
    v[6]  = '{16'h8058, 1, 32'hDEAD_BEEF, 4'b0101, 32'h0, 0, 1, 0, 0, 1};
    v[7]  = '{16'h8058, 0, 32'h0, 4'hF, 32'h00AD_00EF, 0, 1, 0, 0, 0};
    v[8]  = '{16'h0008, 1, 32'h0000_0012, 4'b1110, 32'h0, 0, 0, 0, 0, 0};
    v[9]  = '{16'h0008, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0, 0, 0};
    v[10] = '{16'h2580, 0, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 0};
    v[11] = '{16'h805C, 1, 32'h1122_3344, 4'hF, 32'h0, 0, 1, 0, 0, 1};
    v[12] = '{16'h8058, 1, 32'hFFFF_FFFF, 4'b1000, 32'h0, 0, 1, 0, 0, 1};
    v[13] = '{16'h8058, 0, 32'h0, 4'hF, 32'hFFAD_00EF, 0, 1, 0, 0, 0};
    v[14] = '{16'h805C, 0, 32'h0, 4'hF, 32'h1122_3344, 0, 1, 0, 0, 0};
    v[15] = '{16'h8050, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0, 0, 0};
    v[16] = '{16'h8800, 0, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 0};
    v[17] = '{16'h7FFC, 1, 32'h0000_0066, 4'hF, 32'h0, 1, 0, 0, 0, 0};
    v[18] = '{16'h257C, 1, 32'h0000_007F, 4'hF, 32'h0, 0, 0, 1, 0, 0};
    v[19] = '{16'h257C, 0, 32'h0, 4'hF, 32'h7F, 0, 1, 0, 0, 0};

    apb.paddr_i = '0; apb.pwdata_i = '0; apb.pstrb_i = 4'hF;
    idle_bus();
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    chk("rst_addrs", 128'({ch_map_addr, col_map_addr, ch_t_addr}), 128'd0);
    chk("rst_data", 128'({ch_map_wd, col_map_wd}), 128'd0);
    chk("rst_gdata", ch_t_wd, 128'd0);
    arstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      c0 = n_chw; k0 = n_colw; g0 = n_gw;
      xfer(v[i].a, v[i].w, v[i].d, v[i].s, rd, er, ws);
      chk($sformatf("v%0d_prdata", i), 128'(rd), 128'(v[i].rd));
      chk($sformatf("v%0d_pslverr", i), 128'(er), 128'(v[i].er));
      chk($sformatf("v%0d_waits", i), 128'(ws), 128'(v[i].ws));
      chk($sformatf("v%0d_chw", i), 128'(n_chw - c0), 128'(v[i].chw));
      chk($sformatf("v%0d_colw", i), 128'(n_colw - k0), 128'(v[i].colw));
      chk($sformatf("v%0d_gw", i), 128'(n_gw - g0), 128'(v[i].gw));
      if (i == 0) begin
        chk("v0_addr", 128'(last_cha), 128'd1);
        chk("v0_data", 128'(last_chd), 128'h85);
      end
      if (i == 2) chk("v2_addr", 128'(last_cola), 128'd2399);
      if (i == 6) begin
        chk("v6_gaddr", 128'(last_ga), 128'd5);
        chk("v6_gdata", last_gd, 128'h0000_0000_00AD_00EF_0000_0000_0000_0000);
      end
    end
    chk("final_gdata", last_gd,
        128'h1122_3344_FFAD_00EF_0000_0000_0000_0000);

    // reset lands in ACC1 of a glyph write
    g0 = n_gw;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0;
    apb.paddr_i = 16'h8040; apb.pwrite_i = 1'b1;
    apb.pwdata_i = 32'hCAFE_BABE; apb.pstrb_i = 4'hF;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    arstn = 1'b0;
    @(negedge clk);
    chk_quiet("arst");
    chk("arst_addrs", 128'({ch_map_addr, col_map_addr, ch_t_addr}), 128'd0);
    chk("arst_gdata", ch_t_wd, 128'd0);
    @(posedge clk); @(negedge clk);
    chk_quiet("arst2");
    idle_bus();
    arstn = 1'b1;
    chk("arst_no_gw", 128'(n_gw - g0), 128'd0);
    xfer(16'h8040, 0, 32'h0, 4'hF, rd, er, ws);
    chk("arst_rd", 128'(rd), 128'd0);
    chk("arst_rd_waits", 128'(ws), 128'd1);
    xfer(16'h8040, 1, 32'hCAFE_BABE, 4'hF, rd, er, ws);
    xfer(16'h8040, 0, 32'h0, 4'hF, rd, er, ws);
    chk("arst_after_rd", 128'(rd), 128'hCAFE_BABE);

    // psel drops during ACC1 of a glyph write
    g0 = n_gw;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0;
    apb.paddr_i = 16'h8060; apb.pwrite_i = 1'b1;
    apb.pwdata_i = 32'h1234_5678; apb.pstrb_i = 4'hF;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk_quiet("abort");
    @(posedge clk); @(negedge clk);
    chk_quiet("abort2");
    chk("abort_no_gw", 128'(n_gw - g0), 128'd0);
    xfer(16'h8060, 0, 32'h0, 4'hF, rd, er, ws);
    chk("abort_rd", 128'(rd), 128'd0);
    chk("abort_rd_waits", 128'(ws), 128'd1);
    chk("abort_rd_err", 128'(er), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
